// File: rtl/leaf_net_interface_if.sv
// Core-side TX/RX handshakes and the hub up/down link of one leaf endpoint.
// slave is the leaf endpoint; master is the core and hub side that drives it.
interface leaf_net_interface_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_dst;
    logic [11:0] tx_payload;
    logic [19:0] up_data;
    logic        up_valid;
    logic        up_ci;
    logic [19:0] down_data;
    logic        down_valid;
    logic        down_co;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  rx_src;
    logic [11:0] rx_payload;

    modport slave (
        input  tx_valid, tx_dst, tx_payload,
        input  up_ci,
        input  down_data, down_valid,
        input  rx_ready,
        output tx_ready,
        output up_data, up_valid,
        output down_co,
        output rx_valid, rx_src, rx_payload
    );

    modport master (
        output tx_valid, tx_dst, tx_payload,
        output up_ci,
        output down_data, down_valid,
        output rx_ready,
        input  tx_ready,
        input  up_data, up_valid,
        input  down_co,
        input  rx_valid, rx_src, rx_payload
    );
endinterface

// File: rtl/leaf_net_interface.sv
// Leaf endpoint of a hub link: credit-controlled TX injection and
// address-checked RX buffering with per-slot credit return.
module leaf_net_interface #(
    parameter int CREDITS  = 4,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           my_cluster,
    input  logic [1:0]           my_local,
    leaf_net_interface_if.slave  net,
    output logic [7:0]           misroute_cnt,
    output logic                 proto_err
);
    localparam int TIW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int TCW = $clog2(TX_DEPTH + 1);
    localparam int RIW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int RCW = $clog2(RX_DEPTH + 1);
    localparam int PW  = $clog2(RX_DEPTH + 3);

    localparam logic [2:0]     CRED_MAX = 3'(CREDITS);
    localparam logic [TCW-1:0] TX_FULL  = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RX_FULL  = RCW'(RX_DEPTH);

    function automatic logic [TIW-1:0] tx_inc(input logic [TIW-1:0] p);
        return (p == TIW'(TX_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RIW-1:0] rx_inc(input logic [RIW-1:0] p);
        return (p == RIW'(RX_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [19:0]    tx_mem_q [TX_DEPTH];
    logic [19:0]    tx_mem_d [TX_DEPTH];
    logic [TIW-1:0] tx_wp_q, tx_wp_d;
    logic [TIW-1:0] tx_rp_q, tx_rp_d;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]     credit_q, credit_d;
    logic [19:0]    up_data_q, up_data_d;
    logic           up_valid_q, up_valid_d;

    logic [15:0]    rx_mem_q [RX_DEPTH];
    logic [15:0]    rx_mem_d [RX_DEPTH];
    logic [RIW-1:0] rx_wp_q, rx_wp_d;
    logic [RIW-1:0] rx_rp_q, rx_rp_d;
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
    logic [PW-1:0]  pend_q, pend_d;
    logic           down_co_q, down_co_d;
    logic [7:0]     misroute_q, misroute_d;
    logic           perr_q, perr_d;

    logic        tx_full, tx_empty, tx_push, tx_send;
    logic        tx_bypass, tx_wr, tx_rd, ci_spurious;
    logic [19:0] tx_flit;
    logic        rx_match, rx_full, rx_empty, rx_pop;
    logic        rx_wr, rx_ovf, rx_mis;
    logic [PW-1:0] pend_avail;

    // An empty FIFO is bypassed straight into the output register.
    always_comb begin
        tx_full    = (tx_cnt_q == TX_FULL);
        tx_empty   = (tx_cnt_q == '0);
        tx_push    = net.tx_valid & ~tx_full;
        tx_flit    = {net.tx_dst, my_cluster, my_local, net.tx_payload};
        tx_send    = (credit_q != '0) & (~tx_empty | tx_push);
        tx_bypass  = tx_send & tx_empty;
        tx_wr      = tx_push & ~tx_bypass;
        tx_rd      = tx_send & ~tx_empty;
        up_valid_d = tx_send;
        up_data_d  = '0;
        if (tx_send) begin
            up_data_d = tx_empty ? tx_flit : tx_mem_q[tx_rp_q];
        end
        tx_mem_d = tx_mem_q;
        if (tx_wr) begin
            tx_mem_d[tx_wp_q] = tx_flit;
        end
        tx_wp_d  = tx_wr ? tx_inc(tx_wp_q) : tx_wp_q;
        tx_rp_d  = tx_rd ? tx_inc(tx_rp_q) : tx_rp_q;
        tx_cnt_d = tx_cnt_q + TCW'(tx_wr) - TCW'(tx_rd);
    end

    always_comb begin
        ci_spurious = net.up_ci & ~tx_send & (credit_q == CRED_MAX);
        credit_d    = credit_q;
        unique case ({net.up_ci, tx_send})
            2'b10: begin
                if (!ci_spurious) begin
                    credit_d = credit_q + 3'd1;
                end
            end
            2'b01:   credit_d = credit_q - 3'd1;
            default: credit_d = credit_q;
        endcase
    end

    // A pop frees a slot, so a write into a full FIFO in the same cycle fits.
    always_comb begin
        rx_match = (net.down_data[19:16] == {my_cluster, my_local});
        rx_full  = (rx_cnt_q == RX_FULL);
        rx_empty = (rx_cnt_q == '0);
        rx_pop   = ~rx_empty & net.rx_ready;
        rx_wr    = net.down_valid & rx_match & (~rx_full | rx_pop);
        rx_ovf   = net.down_valid & rx_match & rx_full & ~rx_pop;
        rx_mis   = net.down_valid & ~rx_match;
        rx_mem_d = rx_mem_q;
        if (rx_wr) begin
            rx_mem_d[rx_wp_q] = net.down_data[15:0];
        end
        rx_wp_d  = rx_wr ? rx_inc(rx_wp_q) : rx_wp_q;
        rx_rp_d  = rx_pop ? rx_inc(rx_rp_q) : rx_rp_q;
        rx_cnt_d = rx_cnt_q + RCW'(rx_wr) - RCW'(rx_pop);
    end

    // Freed slots are returned one per cycle, the first without delay.
    always_comb begin
        pend_avail = pend_q + PW'(rx_pop) + PW'(rx_mis);
        down_co_d  = (pend_avail != '0);
        pend_d     = pend_avail - PW'(down_co_d);
        misroute_d = misroute_q;
        if (rx_mis && misroute_q != 8'hFF) begin
            misroute_d = misroute_q + 8'd1;
        end
        perr_d = perr_q | ci_spurious | rx_ovf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
            end
            for (int i = 0; i < RX_DEPTH; i++) begin
                rx_mem_q[i] <= '0;
            end
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            credit_q   <= CRED_MAX;
            up_data_q  <= '0;
            up_valid_q <= 1'b0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            pend_q     <= '0;
            down_co_q  <= 1'b0;
            misroute_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            credit_q   <= credit_d;
            up_data_q  <= up_data_d;
            up_valid_q <= up_valid_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            pend_q     <= pend_d;
            down_co_q  <= down_co_d;
            misroute_q <= misroute_d;
            perr_q     <= perr_d;
        end
    end

    assign net.tx_ready   = ~tx_full;
    assign net.up_data    = up_data_q;
    assign net.up_valid   = up_valid_q;
    assign net.down_co    = down_co_q;
    assign net.rx_valid   = ~rx_empty;
    assign net.rx_src     = rx_empty ? 4'h0 : rx_mem_q[rx_rp_q][15:12];
    assign net.rx_payload = rx_empty ? 12'h000 : rx_mem_q[rx_rp_q][11:0];
    assign misroute_cnt   = misroute_q;
    assign proto_err      = perr_q;
endmodule

// File: doc/leaf_net_interface.md
Name: leaf_net_interface

Overview:
- Leaf-side endpoint for one hub down/up port pair: it is the far end of the hub's leaf link.
- TX path: packs core requests into 20-bit single-flit packets and injects them toward the hub under credit flow control.
- RX path: buffers flits arriving from the hub, checks that each flit is addressed to this leaf, delivers it to the core, and returns one credit per freed slot.
- One instance per leaf tile; it sits between the leaf core and the hub's 7-port router.

Parameters:
CREDITS, 4, initial TX credit count; equals the hub input buffer depth for this port (1..7)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 4, RX FIFO entries (power of 2); must be >= the credits the hub holds for this leaf

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
my_cluster  in  2  this leaf's cluster id (static)
my_local  in  2  this leaf's local id within the cluster, 1..3 (static)
tx_valid  in  1  core offers a packet
tx_ready  out  1  TX FIFO not full
tx_dst  in  4  {dst_cluster, dst_local}
tx_payload  in  12  payload
up_data  out  20  flit to hub
up_valid  out  1  up_data valid this cycle
up_ci  in  1  one-cycle credit-return pulse from hub
down_data  in  20  flit from hub
down_valid  in  1  down_data valid
down_co  out  1  one-cycle credit pulse to hub, one per freed RX slot
rx_valid  out  1  RX FIFO head valid
rx_ready  in  1  core pops head
rx_src  out  4  {src_cluster, src_local} of head
rx_payload  out  12  payload of head
misroute_cnt  out  8  saturating count of dropped misaddressed flits
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Flit format: [19:18] dst_cluster, [17:16] dst_local, [15:14] src_cluster, [13:12] src_local, [11:0] payload. Src fields are filled from my_cluster/my_local.
- Reset (rst=0, asynchronous): FIFOs empty, credit counter = CREDITS, pending-credit counter = 0, misroute_cnt = 0. All outputs 0 except tx_ready = 1. up_data and rx_* read 0.
- TX accept: the core transfer completes when tx_valid & tx_ready at a rising edge. tx_ready is 0 iff the TX FIFO is full.
- TX send: when the TX FIFO is non-empty and credit > 0, pop one flit into the registered up_data/up_valid and decrement credit. At most 1 flit per cycle.
  - Minimum latency: accept at edge N gives up_valid=1 in cycle N+1 (the empty FIFO is bypassed into the output register).
  - up_valid is a single-cycle pulse per flit; there is no stall once it is asserted.
- Credit counter:
  - up_ci alone: +1.
  - Send alone: -1.
  - up_ci together with send: unchanged.
  - up_ci with counter == CREDITS and no send in the same cycle: ignored and proto_err is set.
  - credit == 0: no send; the TX FIFO holds.
- RX: on down_valid, check dst_cluster == my_cluster and dst_local == my_local.
  - Match and FIFO not full: write the flit.
  - Mismatch: drop the flit, increment misroute_cnt (saturating at 255), increment pending credits.
  - Match and FIFO full: drop the flit and set proto_err. No credit is returned.
- RX delivery: rx_valid = FIFO non-empty. rx_src and rx_payload come from the head entry. A pop on rx_valid & rx_ready increments pending credits.
  - Write at edge N gives rx_valid in cycle N+1.
  - A simultaneous write and pop on a full FIFO is legal; the write succeeds.
- Credit return:
  - Pending credits count up to RX_DEPTH+1. A pop and a drop in the same cycle add 2.
  - down_co is registered: 1 in every cycle after an edge where pending > 0 and is being decremented. Each pulse is exactly 1 cycle and at most one pulse per cycle. Back-to-back events give back-to-back pulses.
  - Pop at edge N with pending=0 gives down_co=1 in cycle N+1.
- proto_err clears only on reset.
- Reset mid-operation: all in-flight FIFO contents and pending credits are discarded. The hub is expected to reset together with the leaf.

Test Plan:
- Reset values with my_cluster=2, my_local=1: tx_ready=1, up_valid=0, rx_valid=0, down_co=0, misroute_cnt=0, proto_err=0. Assert rst mid-stream -> all outputs return to these values on the same edge.
- Credit exhaustion, CREDITS=4, no up_ci, push 6 packets with tx_dst=4'h6 and payloads 12'h001..006 -> exactly 4 up_valid pulses with up_data={4'h6,4'h9,12'h001}..{4'h6,4'h9,12'h004}. Then 1 up_ci pulse -> flit 005 sent the next cycle. No 6th send until another up_ci.
- RX match, down_data={4'h9,4'h3,12'hABC} -> rx_valid next cycle, rx_src=4'h3, rx_payload=12'hABC. Pop at edge N -> down_co=1 for exactly cycle N+1.
- Misroute, down_data with dst 4'hA -> no rx_valid, misroute_cnt=1, one down_co pulse. Misroute and pop in the same cycle -> two consecutive down_co pulses.
- RX overflow, RX_DEPTH=4 with rx_ready=0: send 5 matching flits -> rx holds the first 4, proto_err=1, 0 down_co pulses. Then pop 4 -> 4 down_co pulses and contents match in order.
- Spurious credit: up_ci while credit=4 and idle -> proto_err=1 and credit stays 4; verify by sending exactly 4 flits before the send stalls.
